cs161_mc_control: RTL and testbench

CS161_MC_CONTROL -- requirements
Module: cs161_mc_control

---
 rtl/cs161_ctrl_pkg.sv | 52 +++++
 rtl/cs161_alu_decode.sv | 32 +++
 rtl/cs161_mc_control.sv | 168 ++++++++++++++++
 tb/tb_cs161_mc_control.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cs161_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// R-type function codes and ALU control codes.
package cs161_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // True when the opcode (and, for R-type, the function field) is supported.
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: ok = 1'b1;
                    default:                                      ok = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI: ok = 1'b1;
            default:                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cs161_alu_decode.sv
// Maps the latched opcode/function pair to the 4-bit ALU control code.
module cs161_alu_decode
    import cs161_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alu_op
);

    // Pure lookup; unsupported encodings never reach EXEC, so ADD is a safe default.
    always_comb begin
        alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI: alu_op = ALU_ADD;
            OP_BEQ:                alu_op = ALU_SUB;
            OP_SLTI:               alu_op = ALU_SLT;
            default:               alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/cs161_mc_control.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory wait timeout, sticky fault and a retired-instruction counter.
module cs161_mc_control
    import cs161_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  instr_op,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic        reg_dst,
    output logic        branch,
    output logic        mem_read,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_write,
    output logic [3:0]  alu_op,
    output logic        pc_write,
    output logic        ir_write,
    output logic [2:0]  state_out,
    output logic        fault,
    output logic [31:0] retired
);

    // The counter holds the number of earlier stalled cycles in the current
    // wait, so the cycle that would be stall number TIMEOUT_CYCLES is the one
    // where the count equals TIMEOUT_CYCLES-1 and mem_ready is still low.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [5:0]  op_reg, funct_reg;
    logic [7:0]  wait_reg, wait_next;
    logic        fault_reg;
    logic [31:0] retired_reg;
    logic [3:0]  dec_alu_op;
    logic        is_rtype, is_lw, is_sw, is_beq, uses_imm;
    logic        timeout;

    cs161_alu_decode u_alu_decode (
        .op     (op_reg),
        .funct  (funct_reg),
        .alu_op (dec_alu_op)
    );

    assign is_rtype = (op_reg == OP_RTYPE);
    assign is_lw    = (op_reg == OP_LW);
    assign is_sw    = (op_reg == OP_SW);
    assign is_beq   = (op_reg == OP_BEQ);
    assign uses_imm = is_lw | is_sw | (op_reg == OP_ADDI) | (op_reg == OP_SLTI);
    assign timeout  = !mem_ready && (wait_reg == WAIT_LAST);

    // Next state and datapath controls; everything is forced low while reset is held.
    always_comb begin
        state_next = state_reg;
        reg_dst    = 1'b0;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        alu_op     = 4'b0000;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_HALT;
                end
            end
            S_DECODE: begin
                state_next = is_legal(instr_op, funct) ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                alu_op  = dec_alu_op;
                alu_src = uses_imm;
                reg_dst = is_rtype;
                if (is_beq) begin
                    branch     = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (is_lw) begin
                    mem_read = 1'b1;
                    if (mem_ready) state_next = S_WB;
                end else begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        pc_write   = 1'b1;
                        state_next = S_FETCH;
                    end
                end
                if (timeout) state_next = S_HALT;
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = is_lw;
                alu_op     = dec_alu_op;
                alu_src    = uses_imm;
                reg_dst    = is_rtype;
                state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_HALT;
        endcase
        if (!rst) begin
            reg_dst    = 1'b0;
            branch     = 1'b0;
            mem_read   = 1'b0;
            mem_to_reg = 1'b0;
            mem_write  = 1'b0;
            alu_src    = 1'b0;
            reg_write  = 1'b0;
            alu_op     = 4'b0000;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
        end
    end

    // Count consecutive stalled cycles; any state change or ready clears it.
    always_comb begin
        wait_next = 8'd0;
        if ((state_reg == S_FETCH || state_reg == S_MEM) && !mem_ready &&
            state_next == state_reg) begin
            wait_next = wait_reg + 8'd1;
        end
    end

    // State, latched instruction fields, sticky fault and retire counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_FETCH;
            op_reg      <= 6'd0;
            funct_reg   <= 6'd0;
            wait_reg    <= 8'd0;
            fault_reg   <= 1'b0;
            retired_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (state_reg == S_DECODE) begin
                op_reg    <= instr_op;
                funct_reg <= funct;
            end
            if (state_next == S_HALT) fault_reg <= 1'b1;
            if (pc_write) retired_reg <= retired_reg + 32'd1;
        end
    end

    assign state_out = state_reg;
    assign fault     = fault_reg;
    assign retired   = retired_reg;

endmodule

// File: tb/tb_cs161_mc_control.sv
// Randomized transaction-level check of the multicycle control unit.
module tb_cs161_mc_control;

    localparam int TO = 15;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ADDI = 4, K_SLTI = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  instr_op = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        mem_ready = 1'b0;
    logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [3:0]  alu_op;
    logic        pc_write, ir_write;
    logic [2:0]  state_out;
    logic        fault;
    logic [31:0] retired;

    logic [16:0] obs;
    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] exp_ret = 32'd0;

    logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001010};
    logic [5:0] legal_fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};

    always #5 clk = ~clk;

    cs161_mc_control #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .instr_op(instr_op), .funct(funct), .mem_ready(mem_ready),
        .reg_dst(reg_dst), .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
        .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op),
        .pc_write(pc_write), .ir_write(ir_write), .state_out(state_out), .fault(fault),
        .retired(retired)
    );

    assign obs = {state_out, fault, reg_dst, branch, mem_read, mem_to_reg, mem_write,
                  alu_src, reg_write, pc_write, ir_write, alu_op};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, want);
        end
    endtask

    function automatic logic [16:0] mk(input logic [2:0] st, input logic flt,
                                       input logic rd, input logic br, input logic mr,
                                       input logic mtr, input logic mw, input logic as,
                                       input logic rw, input logic pw, input logic iw,
                                       input logic [3:0] aop);
        return {st, flt, rd, br, mr, mtr, mw, as, rw, pw, iw, aop};
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    // Reference decode straight from the instruction table.
    function automatic void classify(input logic [5:0] op, input logic [5:0] fn,
                                     output bit legal, output int kind, output logic [3:0] aop);
        legal = 1'b1;
        kind  = -1;
        aop   = 4'b0010;
        case (op)
            6'b000000: begin
                kind = K_R;
                case (fn)
                    6'b100000: aop = 4'b0010;
                    6'b100010: aop = 4'b0110;
                    6'b100100: aop = 4'b0000;
                    6'b100101: aop = 4'b0001;
                    6'b100111: aop = 4'b1100;
                    6'b101010: aop = 4'b0111;
                    default:   legal = 1'b0;
                endcase
            end
            6'b100011: kind = K_LW;
            6'b101011: kind = K_SW;
            6'b000100: begin kind = K_BEQ; aop = 4'b0110; end
            6'b001000: kind = K_ADDI;
            6'b001010: begin kind = K_SLTI; aop = 4'b0111; end
            default:   legal = 1'b0;
        endcase
    endfunction

    // One clock cycle: entered 1 time unit after a rising edge, samples on the falling edge.
    task automatic step(input logic rdy, input logic [5:0] op, input logic [5:0] fn,
                        input logic [16:0] exp_v, input string tag);
        mem_ready = rdy;
        instr_op  = op;
        funct     = fn;
        @(negedge clk);
        check_val({tag, "_ctl"}, 32'(obs), 32'(exp_v));
        check_val({tag, "_ret"}, retired, exp_ret);
        if (exp_v[5]) exp_ret = exp_ret + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mem_ready = 1'($urandom);
        #1;
        check_val("rst_ctl", 32'(obs), 32'd0);
        check_val("rst_ret", retired, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_ret = 32'd0;
    endtask

    // A memory wait of 'stall' low cycles; returns done=0 when the timeout hits first.
    task automatic wait_phase(input int stall, input logic [16:0] v_wait,
                              input logic [16:0] v_done, input string tag, output bit done);
        int n;
        n = (stall < TO) ? stall : TO;
        for (int k = 0; k < n; k++) step(1'b0, rnd6(), rnd6(), v_wait, tag);
        done = (stall < TO);
        if (done) step(1'b1, rnd6(), rnd6(), v_done, tag);
    endtask

    task automatic halt_phase(input int n);
        for (int k = 0; k < n; k++)
            step(1'($urandom), rnd6(), rnd6(), mk(ST_HALT, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0), "halt");
        do_reset();
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fstall, input int mstall, input int halt_n);
        bit         legal, done;
        int         kind;
        logic [3:0] aop;
        logic       rd, as, br;
        classify(op, fn, legal, kind, aop);
        wait_phase(fstall, mk(ST_FETCH, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'd0),
                   mk(ST_FETCH, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 4'd0), "fetch", done);
        if (!done) begin halt_phase(halt_n); return; end
        step(1'($urandom), op, fn, mk(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0), "decode");
        if (!legal) begin halt_phase(halt_n); return; end
        rd = (kind == K_R);
        br = (kind == K_BEQ);
        as = (kind == K_LW || kind == K_SW || kind == K_ADDI || kind == K_SLTI);
        step(1'($urandom), rnd6(), rnd6(), mk(ST_EXEC, 0, rd, br, 0, 0, 0, as, 0, br, 0, aop), "exec");
        if (br) return;
        if (kind == K_LW) begin
            wait_phase(mstall, mk(ST_MEM, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'd0),
                       mk(ST_MEM, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'd0), "mem_lw", done);
            if (!done) begin halt_phase(halt_n); return; end
        end else if (kind == K_SW) begin
            wait_phase(mstall, mk(ST_MEM, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'd0),
                       mk(ST_MEM, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 4'd0), "mem_sw", done);
            if (!done) begin halt_phase(halt_n); return; end
            return;
        end
        step(1'($urandom), rnd6(), rnd6(),
             mk(ST_WB, 0, rd, 0, 0, kind == K_LW, 0, as, 1, 1, 0, aop), "wb");
    endtask

    function automatic int pick_stall();
        int r;
        r = $urandom_range(0, 19);
        if (r < 16) return $urandom_range(0, 3);
        if (r < 18) return TO - 1;
        return TO;
    endfunction

    initial begin
        logic [5:0] op, fn;
        int r;
        @(posedge clk);
        #1;
        do_reset();
        // Directed cases first.
        run_instr(6'b000000, 6'b100000, 0, 0, 3);   // add
        run_instr(6'b100011, 6'b000000, 0, 3, 3);   // lw with 3 stalled MEM cycles
        run_instr(6'b000100, 6'b000000, 0, 0, 3);   // beq
        run_instr(6'b111111, 6'b000000, 0, 0, 20);  // illegal opcode, then reset
        run_instr(6'b101011, 6'b000000, 0, TO, 3);  // sw timing out in MEM
        run_instr(6'b101011, 6'b000000, 0, TO - 1, 3); // sw, ready on the last allowed cycle
        run_instr(6'b000000, 6'b000001, 0, 0, 3);   // illegal funct
        run_instr(6'b001000, 6'b000000, TO, 0, 3);  // fetch timeout
        do_reset();
        // Reset during the MEM cycle of a store must drop mem_write immediately.
        step(1'b1, rnd6(), rnd6(), mk(ST_FETCH, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 4'd0), "mr_fetch");
        step(1'b0, 6'b101011, 6'd0, mk(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0), "mr_decode");
        step(1'b0, rnd6(), rnd6(), mk(ST_EXEC, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0010), "mr_exec");
        mem_ready = 1'b0;
        @(negedge clk);
        check_val("mr_mem_ctl", 32'(obs), 32'(mk(ST_MEM, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'd0)));
        #2;
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_val("mr_rst_ctl", 32'(obs), 32'd0);
        check_val("mr_rst_ret", retired, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_ret = 32'd0;
        // Randomized instruction stream.
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) op = legal_ops[r];
            else if (r == 6) op = rnd6();
            else op = 6'b000000;
            fn = ($urandom_range(0, 4) != 0) ? legal_fns[$urandom_range(0, 5)] : rnd6();
            run_instr(op, fn, pick_stall(), pick_stall(), 3);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
